// File: rtl/dma_wr_responder_pkg.sv
// Shared DMA definitions: request struct, burst mode, write-response codes and
// beat/boundary constants used by both the streamer and the write responder.
package dma_wr_responder_pkg;

  typedef enum logic {
    MODE_INCR  = 1'b0,
    MODE_FIXED = 1'b1
  } dma_mode_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic [2:0]  size;
    logic [3:0]  strb;
    dma_mode_e   mode;
    logic        valid;
  } dma_req_t;

  localparam logic [1:0]  RESP_OKAY      = 2'd0;
  localparam logic [1:0]  RESP_SLVERR    = 2'd2;
  localparam logic [1:0]  RESP_DECERR    = 2'd3;
  localparam int          DMA_BEAT_BYTES = 4;
  localparam logic [12:0] BOUNDARY_4K    = 13'd4096;
  localparam logic [7:0]  FIXED_MAX_ALEN = 8'd15;

endpackage

// File: rtl/dma_resp_errchk.sv
// Combinational request checker: classifies a DMA write request as OKAY,
// SLVERR (bad size, over-long FIXED, INCR crossing 4 KB) or DECERR (out of range).
module dma_resp_errchk
  import dma_wr_responder_pkg::*;
#(
  parameter int MEM_AW     = 10,
  parameter int BEAT_BYTES = DMA_BEAT_BYTES
) (
  input  dma_req_t   req_i,
  output logic [1:0] resp_o
);

  localparam logic [2:0] SIZE_CODE = 3'($clog2(BEAT_BYTES));

  logic [12:0] end_off_s;
  logic        slverr_s;
  logic        decerr_s;
  logic        unused_bits;

  // 13 bits holds 4095 + 256 * 4, so the boundary sum cannot overflow
  assign end_off_s = {1'b0, req_i.addr[11:0]}
                   + ((13'(req_i.alen) + 13'd1) * 13'(BEAT_BYTES));

  assign slverr_s = (req_i.size != SIZE_CODE)
                 || ((req_i.mode == MODE_FIXED) && (req_i.alen > FIXED_MAX_ALEN))
                 || ((req_i.mode == MODE_INCR) && (end_off_s > BOUNDARY_4K));

  assign decerr_s = ((req_i.addr >> (MEM_AW + 2)) != 32'd0);

  assign unused_bits = ^{req_i.strb, req_i.valid};

  always_comb begin
    resp_o = RESP_OKAY;
    if (slverr_s) begin
      resp_o = RESP_SLVERR;
    end else if (decerr_s) begin
      resp_o = RESP_DECERR;
    end else begin
      resp_o = RESP_OKAY;
    end
  end

endmodule

// File: rtl/dma_wr_responder.sv
// DMA write responder: accepts one burst request, consumes alen+1 beats into a
// registered memory write port and returns a single write response.
module dma_wr_responder
  import dma_wr_responder_pkg::*;
#(
  parameter int MEM_AW     = 10,
  parameter int BEAT_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  input  logic [7:0]        req_alen,
  input  logic [2:0]        req_size,
  input  logic [3:0]        req_strb,
  input  logic              req_mode,
  output logic              req_ready,
  input  logic              wd_valid,
  input  logic [31:0]       wd_data,
  output logic              wd_ready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              b_valid,
  output logic [1:0]        b_resp,
  input  logic              b_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] waddr_q, waddr_d;
  logic [3:0]        strb_q, strb_d;
  dma_mode_e         mode_q, mode_d;
  logic [1:0]        resp_q, resp_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;

  dma_req_t   req_s;
  logic [1:0] chk_resp_s;
  logic       beat_s;

  assign req_s = '{addr: req_addr, alen: req_alen, size: req_size, strb: req_strb,
                   mode: dma_mode_e'(req_mode), valid: req_valid};

  dma_resp_errchk #(
    .MEM_AW     (MEM_AW),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_errchk (
    .req_i  (req_s),
    .resp_o (chk_resp_s)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign wd_ready  = (state_q == ST_DATA);
  assign b_valid   = (state_q == ST_RESP);
  assign b_resp    = resp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign beat_s    = wd_valid && (state_q == ST_DATA);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    strb_d      = strb_q;
    mode_d      = mode_q;
    resp_d      = resp_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_d   = req_alen;
          waddr_d = req_addr[MEM_AW+1:2];
          strb_d  = req_strb;
          mode_d  = dma_mode_e'(req_mode);
          resp_d  = chk_resp_s;
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (beat_s) begin
          // errored bursts are drained without touching memory
          mem_we_d    = (resp_q == RESP_OKAY);
          mem_addr_d  = waddr_q;
          mem_wdata_d = wd_data;
          mem_be_d    = strb_q;
          waddr_d     = (mode_q == MODE_INCR) ? waddr_q + 1'b1 : waddr_q;
          if (cnt_q == 8'd0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RESP: begin
        if (b_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      waddr_q     <= '0;
      strb_q      <= 4'd0;
      mode_q      <= MODE_INCR;
      resp_q      <= RESP_OKAY;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      waddr_q     <= waddr_d;
      strb_q      <= strb_d;
      mode_q      <= mode_d;
      resp_q      <= resp_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

endmodule

// File: doc/dma_wr_responder.md
DMA_WR_RESPONDER -- requirements
Module: dma_wr_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning the word-address width of the attached memory.
REQ-002 SHALL have parameter BEAT_BYTES, default 4, meaning bytes per beat; this is the only supported value.
REQ-003 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  request valid, from the DMA streamer.
REQ-006 req_addr  in  32  byte start address, word aligned.
REQ-007 req_alen  in  8  beats minus one.
REQ-008 req_size  in  3  beat size code; 2 means 4 bytes.
REQ-009 req_strb  in  4  byte strobe, applied to every beat.
REQ-010 req_mode  in  1  burst mode: 0 INCR, 1 FIXED.
REQ-011 req_ready  out  1  request accepted.
REQ-012 wd_valid, wd_data[31:0]  in  1/32  write-beat valid and data.
REQ-013 wd_ready  out  1  write-beat accepted.
REQ-014 mem_we, mem_addr[MEM_AW-1:0], mem_wdata[31:0], mem_be[3:0]  out  memory write port.
REQ-015 b_valid, b_resp[1:0]  out  write response: 0 OKAY, 2 SLVERR, 3 DECERR.
REQ-016 b_ready  in  1  response accepted.

Function
REQ-017 SHALL implement an FSM with states IDLE, DATA and RESP.
REQ-018 IDLE: req_ready=1; on req_valid, capture addr, alen, strb and mode, evaluate errors, and go to DATA on the next cycle.
REQ-019 DATA: wd_ready=1; a beat is accepted when wd_valid&&wd_ready; the beat counter loads alen and decrements on each accepted beat.
REQ-020 Accepting the beat with counter==0 SHALL move the FSM to RESP, with b_valid=1 on the next cycle.
REQ-021 RESP: b_valid held with b_resp stable until b_ready; the cycle after the b_valid&&b_ready handshake SHALL be in IDLE.
REQ-022 mem_* SHALL be registered: a beat accepted in cycle N drives mem_we=1 in cycle N+1 with mem_be=strb, mem_wdata=wd_data and mem_addr=current word address.
REQ-023 Word address SHALL start at req_addr[MEM_AW+1:2]; INCR adds 1 per beat and wraps modulo 2^MEM_AW; FIXED holds the address constant.
REQ-024 SLVERR SHALL be flagged if req_size!=2, or FIXED with alen>15, or INCR where addr[11:0]+(alen+1)*4 > 4096 (13-bit arithmetic).
REQ-025 DECERR SHALL be flagged if req_addr[31:MEM_AW+2]!=0 and no SLVERR applies; SLVERR has priority over DECERR.
REQ-026 On any error, all alen+1 beats SHALL still be consumed, mem_we SHALL stay 0, and b_resp carries the error code.
REQ-027 req_ready SHALL be 0 outside IDLE and wd_ready SHALL be 0 outside DATA; no request is overlapped with an outstanding one.
REQ-028 req_valid seen in DATA or RESP SHALL be ignored until the next IDLE cycle.
REQ-029 A beat bubble (wd_valid=0) SHALL stall the counter and address with no write.

Reset
REQ-030 rst SHALL force IDLE, with req_ready=1 in the first cycle after reset.
REQ-031 Reset values SHALL be: wd_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, b_valid=0, b_resp=0, counter=0.
REQ-032 rst asserted mid-burst SHALL abandon the burst with no response, and the pending registered write SHALL be suppressed.

Structure
REQ-033 A shared package SHALL hold the DMA request struct (addr, alen, size, strb, mode, valid), the mode enum, the b_resp codes, BEAT_BYTES and the 4 KB boundary constant; these definitions are also used by the streamer.
REQ-034 A sub-module dma_resp_errchk (combinational SLVERR/DECERR evaluation from the request) is natural; the FSM, counter and address generation stay in the top.

Verification
REQ-035 INCR addr=0x100, alen=3, strb=F, data 1..4 -> writes at word addresses 0x40..0x43, each mem_we one cycle after its beat; b_resp=0 one cycle after the 4th beat.
REQ-036 FIXED addr=0x20, alen=2, strb=0x3 -> three writes to word 0x08 with be=0x3; b_resp=0.
REQ-037 INCR addr=0xFF8, alen=3 -> crosses 4 KB: 4 beats consumed, no mem_we, b_resp=2; FIXED with alen=16 -> b_resp=2.
REQ-038 addr=0x10000 (MEM_AW=10) -> all beats consumed, no writes, b_resp=3; with req_size=1 as well -> b_resp=2.
REQ-039 Random wd_valid gaps plus b_ready held low 5 cycles -> beat count exact, b_valid/b_resp stable, req_ready low until the handshake completes.
REQ-040 rst pulsed after the 2nd of 4 beats -> no further mem_we, b_valid=0, req_ready=1 the cycle after reset, and a new request is accepted cleanly.
